// File: rtl/frame_motion_sequencer.sv
// Per-frame ball motion sequencer: detects VGA vsync falling edges and
// steps the ball X then Y with edge bounce, publishing one update per frame.
module frame_motion_sequencer #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_MIN    = 0,
    parameter int Y_MAX    = 479,
    parameter int X_CENTER = 320,
    parameter int Y_CENTER = 240,
    parameter int STEP     = 1,
    parameter int SIZE     = 4
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        vs,
    input  logic [7:0]  keycode,
    output logic [9:0]  BallX,
    output logic [9:0]  BallY,
    output logic [9:0]  BallS,
    output logic        update_valid,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] frame_count
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        UPD_X,
        UPD_Y,
        PUBLISH
    } state_t;

    localparam logic [9:0]  STEP_P = 10'(STEP);
    localparam logic [9:0]  STEP_N = 10'(-STEP);
    localparam logic [10:0] X_HI   = 11'(X_MAX - SIZE);
    localparam logic [10:0] X_LO   = 11'(X_MIN + SIZE + STEP);
    localparam logic [10:0] Y_HI   = 11'(Y_MAX - SIZE);
    localparam logic [10:0] Y_LO   = 11'(Y_MIN + SIZE + STEP);

    state_t      state_q, state_d;
    logic        s1_q, s2_q, s3_q;
    logic        vs_fall;
    logic [9:0]  wx_q, wx_d, wy_q, wy_d;
    logic [9:0]  vx_q, vx_d, vy_q, vy_d;
    logic [9:0]  bx_q, bx_d, by_q, by_d;
    logic        uv_q, uv_d;
    logic        ovr_q, ovr_d;
    logic [15:0] fc_q, fc_d;

    // Returns {velocity, position} after one bounded step on one axis.
    function automatic logic [19:0] bounce(
        input logic [9:0]  p,
        input logic [9:0]  v,
        input logic [10:0] lo,
        input logic [10:0] hi
    );
        logic [10:0] sum;
        logic [19:0] res;
        sum = {1'b0, p} + {v[9], v};
        if (!v[9] && (v != '0) && (sum > hi))
            res = {STEP_N, p - STEP_P};
        else if (v[9] && ({1'b0, p} < lo))
            res = {STEP_P, p + STEP_P};
        else
            res = {v, p + v};
        return res;
    endfunction

    assign vs_fall = s3_q & ~s2_q;

    always_comb begin
        state_d = state_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        vx_d    = vx_q;
        vy_d    = vy_q;
        bx_d    = bx_q;
        by_d    = by_q;
        uv_d    = 1'b0;
        fc_d    = fc_q;
        // Edges arriving mid-sequence are dropped but remembered.
        ovr_d   = ovr_q | (vs_fall & (state_q != IDLE));
        unique case (state_q)
            IDLE: begin
                if (vs_fall)
                    state_d = LATCH;
            end
            LATCH: begin
                unique case (1'b1)
                    (keycode == 8'h1A): begin vx_d = '0;     vy_d = STEP_N; end
                    (keycode == 8'h16): begin vx_d = '0;     vy_d = STEP_P; end
                    (keycode == 8'h04): begin vx_d = STEP_N; vy_d = '0;     end
                    (keycode == 8'h07): begin vx_d = STEP_P; vy_d = '0;     end
                    default: ;
                endcase
                state_d = UPD_X;
            end
            UPD_X: begin
                {vx_d, wx_d} = bounce(wx_q, vx_q, X_LO, X_HI);
                state_d = UPD_Y;
            end
            UPD_Y: begin
                {vy_d, wy_d} = bounce(wy_q, vy_q, Y_LO, Y_HI);
                state_d = PUBLISH;
            end
            PUBLISH: begin
                bx_d    = wx_q;
                by_d    = wy_q;
                uv_d    = 1'b1;
                fc_d    = fc_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            s1_q    <= 1'b1;
            s2_q    <= 1'b1;
            s3_q    <= 1'b1;
            wx_q    <= 10'(X_CENTER);
            wy_q    <= 10'(Y_CENTER);
            vx_q    <= '0;
            vy_q    <= '0;
            bx_q    <= 10'(X_CENTER);
            by_q    <= 10'(Y_CENTER);
            uv_q    <= 1'b0;
            ovr_q   <= 1'b0;
            fc_q    <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= vs;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            uv_q    <= uv_d;
            ovr_q   <= ovr_d;
            fc_q    <= fc_d;
        end
    end

    assign BallX        = bx_q;
    assign BallY        = by_q;
    assign BallS        = 10'(SIZE);
    assign update_valid = uv_q;
    assign busy         = (state_q != IDLE);
    assign overrun      = ovr_q;
    assign frame_count  = fc_q;

endmodule

// File: tb/tb_frame_motion_sequencer.sv
// Bench for frame_motion_sequencer: vector table, corner-case sequences and
// randomized frames checked against a frame-level motion model.
module tb_frame_motion_sequencer;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        vs = 1'b1;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  BallX, BallY, BallS;
    logic        update_valid, busy, overrun;
    logic [15:0] frame_count;

    frame_motion_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .vs           (vs),
        .keycode      (keycode),
        .BallX        (BallX),
        .BallY        (BallY),
        .BallS        (BallS),
        .update_valid (update_valid),
        .busy         (busy),
        .overrun      (overrun),
        .frame_count  (frame_count)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level model of the ball.
    int mx, my, mvx, mvy, mfc;

    typedef struct {
        logic [7:0] kc;
        int         ex;
        int         ey;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic void m_reset();
        mx = 320; my = 240; mvx = 0; mvy = 0; mfc = 0;
    endfunction

    function automatic void m_frame(input logic [7:0] kc);
        case (kc)
            8'h1A: begin mvx = 0;  mvy = -1; end
            8'h16: begin mvx = 0;  mvy = 1;  end
            8'h04: begin mvx = -1; mvy = 0;  end
            8'h07: begin mvx = 1;  mvy = 0;  end
            default: ;
        endcase
        if (mvx > 0 && mx + mvx > 639 - 4) begin mvx = -1; mx = mx - 1; end
        else if (mvx < 0 && mx < 0 + 4 + 1) begin mvx = 1; mx = mx + 1; end
        else mx = mx + mvx;
        if (mvy > 0 && my + mvy > 479 - 4) begin mvy = -1; my = my - 1; end
        else if (mvy < 0 && my < 0 + 4 + 1) begin mvy = 1; my = my + 1; end
        else my = my + mvy;
        mfc = (mfc + 1) % 65536;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " BallX"}, int'(BallX), mx);
        chk({tag, " BallY"}, int'(BallY), my);
        chk({tag, " frame_count"}, int'(frame_count), mfc);
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        vs = 1'b1;
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;
        m_reset();
        @(negedge Clk);
    endtask

    // One frame: vs falls at a negedge; optional keycode switch after sw_at.
    task automatic frame(input logic [7:0] kc, input int sw_at,
                         input logic [7:0] kc2);
        int lat;
        keycode = kc;
        vs = 1'b0;
        lat = 0;
        do begin
            @(negedge Clk);
            lat++;
            if (lat == sw_at) keycode = kc2;
        end while (!update_valid && lat < 30);
        chk("latency", lat, 7);
        m_frame(kc);
        check_model("frame");
        vs = 1'b1;
        @(negedge Clk);
        chk("pulse width", int'(update_valid), 0);
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        int pulses;
        int lat;
        int run;
        logic [7:0] k;

        tbl[0] = '{8'h00, 320, 240};
        tbl[1] = '{8'h07, 321, 240};
        tbl[2] = '{8'h55, 322, 240};
        tbl[3] = '{8'h1A, 322, 239};
        tbl[4] = '{8'h00, 322, 238};
        tbl[5] = '{8'h04, 321, 238};
        tbl[6] = '{8'h16, 321, 239};
        tbl[7] = '{8'h07, 322, 239};

        // Reset values
        do_reset();
        chk("rst BallX", int'(BallX), 320);
        chk("rst BallY", int'(BallY), 240);
        chk("rst BallS", int'(BallS), 4);
        chk("rst busy", int'(busy), 0);
        chk("rst overrun", int'(overrun), 0);
        chk("rst frame_count", int'(frame_count), 0);
        chk("rst update_valid", int'(update_valid), 0);

        // busy timing on one frame: vs_fall seen after 2 edges, busy after 3
        keycode = 8'h07;
        vs = 1'b0;
        lat = 0;
        repeat (2) @(negedge Clk);
        chk("busy before", int'(busy), 0);
        @(negedge Clk);
        chk("busy after", int'(busy), 1);
        lat = 3;
        while (!update_valid && lat < 30) begin
            @(negedge Clk);
            lat++;
        end
        chk("latency first", lat, 7);
        m_frame(8'h07);
        vs = 1'b1;
        repeat (4) @(negedge Clk);
        frame(8'h07, 0, 8'h00);
        frame(8'h07, 0, 8'h00);
        chk("D x3 BallX", int'(BallX), 323);
        chk("D x3 BallY", int'(BallY), 240);
        chk("D x3 frame_count", int'(frame_count), 3);

        // Vector table from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            frame(tbl[i].kc, 0, 8'h00);
            chk($sformatf("tbl[%0d] X", i), int'(BallX), tbl[i].ex);
            chk($sformatf("tbl[%0d] Y", i), int'(BallY), tbl[i].ey);
        end

        // Right-edge bounce
        do_reset();
        for (int i = 0; i < 314; i++) frame(8'h07, 0, 8'h00);
        chk("edge pre X", int'(BallX), 634);
        frame(8'h00, 0, 8'h00);
        chk("edge hit X", int'(BallX), 635);
        frame(8'h00, 0, 8'h00);
        chk("edge bounce X", int'(BallX), 634);

        // Key change after LATCH has no effect until next frame
        do_reset();
        frame(8'h1A, 4, 8'h16);
        chk("midkey BallY", int'(BallY), 239);
        frame(8'h16, 0, 8'h00);
        chk("nextkey BallY", int'(BallY), 240);

        // Two vsync edges two cycles apart
        do_reset();
        keycode = 8'h07;
        vs = 1'b0;
        @(negedge Clk);
        vs = 1'b1;
        @(negedge Clk);
        vs = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (update_valid) pulses++;
        end
        vs = 1'b1;
        chk("overrun pulses", pulses, 1);
        chk("overrun set", int'(overrun), 1);
        m_frame(8'h07);
        check_model("overrun");
        repeat (4) @(negedge Clk);
        frame(8'h00, 0, 8'h00);
        chk("overrun sticky", int'(overrun), 1);
        do_reset();
        chk("overrun cleared", int'(overrun), 0);

        // Reset while in UPD_Y
        frame(8'h16, 0, 8'h00);
        keycode = 8'h07;
        vs = 1'b0;
        repeat (5) @(negedge Clk);
        Reset_n = 1'b0;
        vs = 1'b1;
        @(negedge Clk);
        chk("midrst update_valid", int'(update_valid), 0);
        chk("midrst BallX", int'(BallX), 320);
        chk("midrst BallY", int'(BallY), 240);
        chk("midrst busy", int'(busy), 0);
        chk("midrst frame_count", int'(frame_count), 0);
        Reset_n = 1'b1;
        m_reset();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            if (update_valid) pulses++;
        end
        chk("midrst no pulse", pulses, 0);

        // Randomized runs of keys against the model
        do_reset();
        for (int c = 0; c < 25; c++) begin
            case ($urandom_range(0, 5))
                0: k = 8'h1A;
                1: k = 8'h16;
                2: k = 8'h04;
                3: k = 8'h07;
                4: k = 8'h00;
                default: k = 8'($urandom);
            endcase
            frame(k, 0, 8'h00);
            run = $urandom_range(1, 12);
            for (int j = 0; j < run; j++) begin
                k = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h2C;
                frame(k, $urandom_range(4, 6), 8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
